// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: register offsets, STATUS bit positions and UART FSM encoding
package mmio_uart_pkg;
  localparam logic [29:0] REG_TXDATA  = 30'd0;
  localparam logic [29:0] REG_STATUS  = 30'd1;
  localparam logic [29:0] REG_CYCLE   = 30'd2;
  localparam logic [29:0] REG_SCRATCH = 30'd3;
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; pushes while full and pops while empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/mmio_uart.sv
// mmio_uart: MMIO responder with TX FIFO + 8N1 transmitter, status, cycle counter and scratch
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sel,
  input  logic [29:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_wren,
  input  logic [3:0]  i_mask,
  output logic [31:0] o_data,
  output logic        o_tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  logic [1:0] state;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] shift, fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [31:0] cycle, scratch, status, rd_val;
  logic fifo_full, fifo_empty, overflow, wr, push, clr_ovf, bit_end, pop;
  assign wr      = i_sel && i_wren;
  assign push    = wr && i_addr == REG_TXDATA && i_mask[0];
  assign clr_ovf = wr && i_addr == REG_STATUS && i_mask[0] && i_data[ST_OVF];
  assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
  // Popping at the end of STOP chains frames back to back with no idle gap
  assign pop     = !fifo_empty && (state == S_IDLE || (state == S_STOP && bit_end));
  assign o_tx    = state == S_START ? 1'b0 : state == S_DATA ? shift[0] : 1'b1;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(i_data[7:0]),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );
  always_comb begin
    status = '0;
    status[ST_BUSY] = state != S_IDLE;
    status[ST_FULL] = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_OVF] = overflow;
    status[ST_COUNT +: 8] = 8'(fifo_count);
    rd_val = i_addr == REG_STATUS  ? status :
             i_addr == REG_CYCLE   ? cycle :
             i_addr == REG_SCRATCH ? scratch : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      overflow <= 1'b0;
      cycle    <= '0;
      scratch  <= '0;
      o_data   <= '0;
    end else begin
      cycle  <= cycle + 1'b1;
      o_data <= i_sel ? rd_val : '0;
      if (push && fifo_full) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      for (int i = 0; i < 4; i++)
        if (wr && i_addr == REG_SCRATCH && i_mask[i]) scratch[8*i +: 8] <= i_data[8*i +: 8];
      baud <= (state == S_IDLE || bit_end) ? '0 : baud + 1'b1;
      if (pop) shift <= fifo_dout;
      else if (state == S_DATA && bit_end) shift <= shift >> 1;
      case (state)
        S_IDLE:  if (pop) state <= S_START;
        S_START: if (bit_end) begin
          state   <= S_DATA;
          bit_idx <= '0;
        end
        S_DATA:  if (bit_end) begin
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= S_STOP;
        end
        default: if (bit_end) state <= pop ? S_START : S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
MMIO responder at the far end of the crossbar's MMIO port: accepts word-addressed, byte-masked reads and writes from the CPU, with addresses already offset-relative.
Contains:
- a TX FIFO feeding an 8N1 UART transmitter,
- a status register,
- a free-running cycle counter,
- a scratch register.
The system top drives i_sel from the MMIO range decode, because the crossbar drives X on unselected ports.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (>=2)
FIFO_DEPTH, 16, TX FIFO entries; power of two, >=2

Ports:
clk     input   1   clock, all logic rising-edge
rst     input   1   reset; synchronous, active-high
i_sel   input   1   MMIO access strobe; all other i_* inputs are ignored (may be X) when 0
i_addr  input   30  word offset within MMIO window
i_data  input   32  write data
i_wren  input   1   1 = write, 0 = read
i_mask  input   4   byte-lane enables, bit n = i_data[8n+7:8n]
o_data  output  32  read data, registered
o_tx    output  1   UART serial line, idle high

Behaviour:
- Reset state: o_tx=1, o_data=0, FIFO empty, overflow=0, cycle=0, scratch=0, FSM=IDLE.
- Reset mid-frame: o_tx is high the cycle after rst is sampled; the frame is aborted and FIFO contents are discarded.
- Register map (word offsets):
  - 0 TXDATA: write with i_mask[0]=1 pushes i_data[7:0]; i_mask[0]=0 writes are ignored. Reads return 0.
  - 1 STATUS: read-only fields, except overflow:
    - bit0 busy (FSM!=IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), [15:8] FIFO count, other bits 0.
    - Writing with i_mask[0]=1 and i_data[3]=1 clears overflow.
  - 2 CYCLE: 32-bit counter, +1 every cycle; wraps FFFF_FFFF->0; writes ignored.
  - 3 SCRATCH: read/write, byte-masked per lane.
  - Offsets >=4: read 0, writes ignored.
- Read latency 1:
  - In a cycle with i_sel=1, o_data at the next edge takes the register value sampled in that cycle (pre-write value if i_wren=1).
  - In a cycle with i_sel=0, o_data is 0 at the next edge.
  - Reads have no side effects.
- FIFO overflow: a push while full (evaluated on the pre-pop state of the same cycle) is dropped and sets overflow. Same-cycle push and pop when not full both take effect; count is unchanged.
- Overflow set vs clear in the same cycle: set wins.
- UART FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..CLKS_PER_BIT-1; each bit is exactly CLKS_PER_BIT cycles.
  - IDLE: o_tx=1. If FIFO non-empty, pop into the shift register and go to START. The first START cycle is the cycle after the pop.
  - START: o_tx=0 for one bit time, then go to DATA with bit index 0.
  - DATA: o_tx=shift[0], LSB first. Shift after each bit; after bit 7 go to STOP.
  - STOP: o_tx=1 for one bit time. At the end: if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
  - A full frame is 10*CLKS_PER_BIT cycles.
- The byte written is visible in FIFO count the cycle after the write edge. With the FSM idle, the start bit begins 2 cycles after the write edge.

Decomposition:
- Package mmio_uart_pkg:
  - register offsets TXDATA/STATUS/CYCLE/SCRATCH
  - STATUS bit positions
  - FSM state encoding (2-bit)
- Sub-module sync_fifo: parameters WIDTH=8 and DEPTH; ports push, pop, din, dout, full, empty, count. Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- The UART FSM, register file and counter stay in mmio_uart.

Test Plan:
- Reset then read STATUS (CLKS_PER_BIT=4) -> o_data=0x0000_0004 one cycle later; o_tx=1.
- Write 0xA5 to TXDATA (mask 0001) -> o_tx sequence at 4 cycles/bit: 0,1,0,1,0,0,1,0,1,1; busy=1 during frame, 0 after 40 cycles.
- Write 3 bytes back-to-back -> three frames contiguous, no idle cycles between stop and start; STATUS count reads 2 right after the first pop.
- With FIFO_DEPTH=4, write 6 bytes while the line is stalled mid-frame -> 1 in shift register + 4 queued, 1 dropped; STATUS bit3=1, bit1=1. Write STATUS 0x8 -> bit3=0.
- Write 0x1122_3344 to SCRATCH mask 0101, then read -> 0x0022_0044. Read offset 7 -> 0. Two CYCLE reads 5 cycles apart differ by 5.
- Assert rst mid-DATA -> o_tx=1 next cycle; STATUS then reads empty, overflow=0, count 0.
